// File: rtl/tpu_result_collector.sv
// rtl/tpu_result_collector.sv - deskews systolic array columns and writes lane-reversed rows to the result SRAM
// Optional macro RESULT_RELU_EN clamps negative lanes to zero ahead of the output register.
module tpu_result_collector #(
   parameter int PARTIAL_SUM_BW = 24,
   parameter int NUM_COLS       = 128,
   parameter int ADDRESSSIZE    = 10,
   parameter int ROWCNT_BW      = 8,
   parameter int PIPE_LATENCY   = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic [ADDRESSSIZE-1:0]             base_addr,
   input  logic [ROWCNT_BW-1:0]               num_rows,
   input  logic [PARTIAL_SUM_BW*NUM_COLS-1:0] result_in,
   output logic                               busy,
   output logic                               done,
   output logic                               start_err,
   output logic                               sram_we,
   output logic [ADDRESSSIZE-1:0]             sram_addr,
   output logic [PARTIAL_SUM_BW*NUM_COLS-1:0] sram_wdata
);

   localparam int BW      = PARTIAL_SUM_BW;
   localparam int T0      = PIPE_LATENCY + NUM_COLS;
   localparam int WCNT_BW = $clog2(T0 + 1);
   localparam logic [WCNT_BW-1:0]     WAIT_LOAD = WCNT_BW'(T0 - 1);
   localparam logic [WCNT_BW-1:0]     WCNT_ONE  = WCNT_BW'(1);
   localparam logic [ROWCNT_BW-1:0]   ROW_ONE   = ROWCNT_BW'(1);
   localparam logic [ADDRESSSIZE-1:0] ADDR_ONE  = ADDRESSSIZE'(1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE, S_DONE} state_t;

   state_t                       state_q;
   logic [WCNT_BW-1:0]           wcnt_q;
   logic [ROWCNT_BW-1:0]         rows_q;
   logic [ADDRESSSIZE-1:0]       base_q;
   logic [ADDRESSSIZE-1:0]       addr_q;
   logic                         busy_q;
   logic                         done_q;
   logic                         err_q;
   logic                         we_q;
   logic [BW*NUM_COLS-1:0]       wdata_d;
   logic [BW*NUM_COLS-1:0]       wdata_q;
   logic [NUM_COLS-1:0][BW-1:0]  lane_dsk;

   // Lane c arrives c cycles after lane 0, so it is delayed NUM_COLS-1-c stages to line up.
   for (genvar c = 0; c < NUM_COLS; c++) begin : g_lane
      localparam int D = NUM_COLS - 1 - c;
      if (D == 0) begin : g_pass
         assign lane_dsk[c] = result_in[c*BW +: BW];
      end else begin : g_dly
         logic [BW-1:0] sh_q [D];
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < D; i++) sh_q[i] <= '0;
            end else begin
               sh_q[0] <= result_in[c*BW +: BW];
               for (int i = 1; i < D; i++) sh_q[i] <= sh_q[i-1];
            end
         end
         assign lane_dsk[c] = sh_q[D-1];
      end
   end

   always_comb begin
      wdata_d = '0;
      for (int k = 0; k < NUM_COLS; k++) begin
`ifdef RESULT_RELU_EN
         wdata_d[k*BW +: BW] = lane_dsk[NUM_COLS-1-k][BW-1] ? {BW{1'b0}} : lane_dsk[NUM_COLS-1-k];
`else
         wdata_d[k*BW +: BW] = lane_dsk[NUM_COLS-1-k];
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) wdata_q <= '0;
      else     wdata_q <= wdata_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         wcnt_q  <= '0;
         rows_q  <= '0;
         base_q  <= '0;
         addr_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
      end else begin
         err_q  <= start && (state_q != S_IDLE);
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  base_q  <= base_addr;
                  rows_q  <= num_rows;
                  wcnt_q  <= WAIT_LOAD;
                  busy_q  <= 1'b1;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               wcnt_q <= wcnt_q - WCNT_ONE;
               // Outputs are registered, so leave WAIT one cycle early to land the first write at T0.
               if (wcnt_q == WCNT_ONE) begin
                  if (rows_q == '0) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     we_q    <= 1'b1;
                     addr_q  <= base_q;
                     state_q <= S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               if (rows_q == ROW_ONE) begin
                  we_q    <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  rows_q <= rows_q - ROW_ONE;
                  addr_q <= addr_q + ADDR_ONE;
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign start_err  = err_q;
   assign sram_we    = we_q;
   assign sram_addr  = addr_q;
   assign sram_wdata = wdata_q;

endmodule

// File: doc/tpu_result_collector.md
Name: tpu_result_collector

Overview:
- Parametrised successor to the fixed 7-bit-counter result capture path.
- Takes the diagonally skewed partial-sum outputs of the systolic array and deskews all columns into a single aligned row.
- Writes each row, lane-reversed, into the result SRAM under a start/busy/done handshake.
- Row count, base address, array latency and column count are all configurable; the previous hardwired 64-row, address-0 capture is replaced.

Parameters:
PARTIAL_SUM_BW, 24, bit width of one signed column result
NUM_COLS, 128, systolic array columns (result lanes), >=2
ADDRESSSIZE, 10, result SRAM address width
ROWCNT_BW, 8, width of runtime row count
PIPE_LATENCY, 8, cycles from accepted start to column-0 row-0 result at result_in

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle request; base_addr and num_rows sampled with it
base_addr  input  ADDRESSSIZE  first SRAM write address
num_rows  input  ROWCNT_BW  rows to capture (0 allowed)
result_in  input  PARTIAL_SUM_BW*NUM_COLS  skewed array output; lane c at bits [c*BW +: BW]
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
start_err  output  1  one-cycle pulse: start received while busy
sram_we  output  1  result SRAM write enable
sram_addr  output  ADDRESSSIZE  result SRAM address
sram_wdata  output  PARTIAL_SUM_BW*NUM_COLS  aligned, reversed row

Behaviour:
- Reset (asynchronous, while rst=1): all outputs 0, FSM=IDLE, counters 0. Deskew registers are also cleared to 0.
- Deskew: lane c passes through NUM_COLS-1-c register stages, then one common output stage.
  - Deskew runs every cycle regardless of FSM state.
  - Lane NUM_COLS-1 has zero deskew stages.
- Reversal: sram_wdata lane k = deskewed lane NUM_COLS-1-k. This is pure wiring ahead of the output register.
- Timing reference: the cycle in which start is accepted is cycle 0.
  - Lane c of row r is valid on result_in in cycle PIPE_LATENCY+c+r.
  - First write T0 = PIPE_LATENCY+NUM_COLS.
  - Row i is written in cycle T0+i with sram_addr = base_addr+i, wrapping modulo 2^ADDRESSSIZE.
- FSM:
  - IDLE: on start, latch base_addr/num_rows, load wait counter with T0-1, go to WAIT. busy=1 from cycle 1.
  - WAIT: decrement the counter; at 0 go to WRITE, or to DONE if num_rows==0.
  - WRITE: sram_we=1 for exactly num_rows consecutive cycles, address incrementing; after the last write go to DONE.
  - DONE: done=1 for one cycle, busy still 1; next state IDLE, busy=0.
- start while not IDLE: ignored (latched values unchanged, no restart); start_err pulses the following cycle.
- start in the same cycle DONE is left: ignored with start_err. The earliest accepted restart is the cycle after done.
- num_rows=0: no writes; done at cycle T0.
- Address wrap: base_addr=2^ADDRESSSIZE-1 writes rows at addresses max, 0, 1, ...
- rst asserted mid-operation: immediate return to IDLE, sram_we drops to 0 asynchronously, no done pulse.
- Arithmetic: none except in the optional feature; data passes through bit-exact.

Optional Feature:
- Macro RESULT_RELU_EN.
- Defined: each lane is clamped before the output register; a negative signed value (MSB=1) becomes 0, non-negative passes. Timing is unchanged.
- Undefined: lanes pass unmodified (two's-complement preserved).

Test Plan:
- Common setup for all scenarios: NUM_COLS=4, PIPE_LATENCY=3, PARTIAL_SUM_BW=8, ADDRESSSIZE=4, so T0=7.
- Basic capture:
  - Stimulus: start with base=2, num_rows=3; feed rows {1,2,3,4}, {5,6,7,8}, {9,10,11,12} skewed per lane.
  - Response: writes at cycles 7, 8, 9 to addresses 2, 3, 4 with lanes (low→high) {4,3,2,1}, {8,7,6,5}, {12,11,10,9}; done at cycle 10; busy cycles 1–10.
- Wrap:
  - Stimulus: base=15, num_rows=3.
  - Response: addresses 15, 0, 1.
- Zero rows:
  - Stimulus: num_rows=0.
  - Response: sram_we never 1; done at cycle 7.
- Start while busy:
  - Stimulus: second start at cycle 4 with base=9.
  - Response: start_err=1 at cycle 5; writes still go to the original base; one done only.
- Reset mid-write:
  - Stimulus: rst pulse at cycle 8.
  - Response: sram_we=0, busy=0 immediately; no done. A new start after release runs normally from IDLE.
- RELU_EN:
  - Stimulus: row {-5, 7, -128, 0} with RESULT_RELU_EN defined.
  - Response: written lanes {0, 0, 7, 0}.
  - Same row with the macro undefined: written lanes {0, -128, 7, -5}.
